// File: rtl/wb_burst_reader.sv
// Wishbone B3 read-only burst master: fetches xfer_words into a FWFT FIFO; words visible 1 cycle after ack.
// Bursts wait for reserved FIFO space, so a stalled consumer throttles the bus side. `WB_READER_ERR_EN enables bus-error abort.
module wb_burst_reader #(
  parameter int BURST_LEN  = 8,
  parameter int FIFO_DEPTH = 32,
  parameter int CNT_W      = 16
) (
  input  logic                        wb_clk,
  input  logic                        wb_rst_n,
  input  logic                        start_i,
  input  logic [31:0]                 base_adr_i,
  input  logic [CNT_W-1:0]            xfer_words_i,
  output logic                        busy_o,
  output logic                        done_o,
  output logic                        err_o,
  output logic [31:0]                 wbm_adr_o,
  output logic [1:0]                  wbm_bte_o,
  output logic [2:0]                  wbm_cti_o,
  output logic                        wbm_cyc_o,
  output logic                        wbm_stb_o,
  output logic                        wbm_we_o,
  output logic [3:0]                  wbm_sel_o,
  output logic [31:0]                 wbm_dat_o,
  input  logic [31:0]                 wbm_dat_i,
  input  logic                        wbm_ack_i,
  input  logic                        wbm_err_i,
  input  logic                        wbm_rty_i,
  output logic [31:0]                 rd_data_o,
  output logic                        rd_valid_o,
  input  logic                        rd_ready_i,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level_o
);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int LW = AW + 1;
  localparam int BW = $clog2(BURST_LEN) + 1;

  typedef enum logic [1:0] {IDLE, WAIT_SPACE, BURST, GAP} state_t;

  state_t           state, state_nxt;
  logic [31:0]      adr, adr_nxt;
  logic [CNT_W-1:0] rem, rem_nxt;
  logic [BW-1:0]    beats, beats_nxt, beats_req;
  logic             done_q, done_nxt;
  logic             err_q, err_nxt;
  logic             err_hit, push, pop, space_ok;
  logic [LW-1:0]    level, free_cnt;
  logic [AW-1:0]    wr_ptr, rd_ptr;
  logic [31:0]      mem [FIFO_DEPTH];
  logic             unused_ok;

`ifdef WB_READER_ERR_EN
  assign err_hit = (state == BURST) && wbm_err_i;
`else
  assign err_hit = 1'b0;
`endif

  assign unused_ok = ^{base_adr_i[1:0], wbm_rty_i, wbm_err_i};

  assign beats_req = (rem >= CNT_W'(BURST_LEN)) ? BW'(BURST_LEN) : rem[BW-1:0];
  assign free_cnt  = LW'(FIFO_DEPTH) - level;
  assign space_ok  = (free_cnt >= LW'(beats_req));

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      state  <= IDLE;
      adr    <= '0;
      rem    <= '0;
      beats  <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nxt;
      adr    <= adr_nxt;
      rem    <= rem_nxt;
      beats  <= beats_nxt;
      done_q <= done_nxt;
      err_q  <= err_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    adr_nxt   = adr;
    rem_nxt   = rem;
    beats_nxt = beats;
    done_nxt  = 1'b0;
    err_nxt   = err_q;
    push      = 1'b0;
    case (state)
      IDLE: begin
        if (start_i) begin
          adr_nxt = {base_adr_i[31:2], 2'b00};
          rem_nxt = xfer_words_i;
          err_nxt = 1'b0;
          if (xfer_words_i == '0) done_nxt = 1'b1;
          else                    state_nxt = WAIT_SPACE;
        end
      end
      WAIT_SPACE: begin
        if (space_ok) begin
          beats_nxt = beats_req;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (err_hit) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          err_nxt   = 1'b1;
        end else if (wbm_ack_i) begin
          push      = 1'b1;
          adr_nxt   = adr + 32'd4;
          rem_nxt   = rem - CNT_W'(1);
          beats_nxt = beats - BW'(1);
          if (beats == BW'(1)) begin
            if (rem == CNT_W'(1)) begin
              state_nxt = IDLE;
              done_nxt  = 1'b1;
            end else begin
              state_nxt = GAP;
            end
          end
        end
      end
      GAP: begin
        // The single cyc-low cycle already lets the arbiter switch; skip the wait when space is there.
        if (space_ok) begin
          beats_nxt = beats_req;
          state_nxt = BURST;
        end else begin
          state_nxt = WAIT_SPACE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign busy_o    = (state != IDLE);
  assign done_o    = done_q;
  assign err_o     = err_q;
  assign wbm_adr_o = adr;
  assign wbm_cyc_o = (state == BURST);
  assign wbm_stb_o = (state == BURST);
  assign wbm_cti_o = (state != BURST) ? 3'b000 : ((beats == BW'(1)) ? 3'b111 : 3'b010);
  assign wbm_bte_o = 2'b00;
  assign wbm_we_o  = 1'b0;
  assign wbm_sel_o = 4'hF;
  assign wbm_dat_o = 32'h0;

  assign rd_valid_o   = (level != '0);
  assign rd_data_o    = rd_valid_o ? mem[rd_ptr] : 32'h0;
  assign pop          = rd_valid_o & rd_ready_i;
  assign fifo_level_o = level;

  always_ff @(posedge wb_clk or negedge wb_rst_n) begin
    if (!wb_rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      level <= level + LW'(push) - LW'(pop);
    end
  end

  always_ff @(posedge wb_clk) begin
    if (push) mem[wr_ptr] <= wbm_dat_i;
  end

endmodule

// File: tb/tb_wb_burst_reader.sv
// Directed bench for wb_burst_reader with a zero-wait Wishbone slave returning adr ^ 0xDEAD0000.
module tb_wb_burst_reader;
  logic        wb_clk = 1'b0;
  logic        wb_rst_n = 1'b0;
  logic        start_i = 1'b0;
  logic [31:0] base_adr_i = '0;
  logic [15:0] xfer_words_i = '0;
  logic        busy_o, done_o, err_o;
  logic [31:0] wbm_adr_o, wbm_dat_o, wbm_dat_i, rd_data_o;
  logic [1:0]  wbm_bte_o;
  logic [2:0]  wbm_cti_o;
  logic        wbm_cyc_o, wbm_stb_o, wbm_we_o;
  logic [3:0]  wbm_sel_o;
  logic        wbm_ack_i, wbm_err_i;
  logic        wbm_rty_i = 1'b0;
  logic        rd_valid_o;
  logic        rd_ready_i = 1'b0;
  logic [5:0]  fifo_level_o;

  logic        err_arm = 1'b0;
  logic        err_drop = 1'b0;
  logic [31:0] err_adr = '0;

  int checks = 0;
  int errors = 0;

  logic [31:0] adr_q[$];
  logic [2:0]  cti_q[$];
  logic [31:0] rx_q[$];
  int          gap_q[$];
  int cyc_n = 0, last_ack_cyc = 0, done_cyc = 0, max_level = 0;
  int low_run = 0, cyc_cnt = 0, busy_cnt = 0;
  logic cyc_prev = 1'b0;

  always #5 wb_clk = ~wb_clk;

  assign wbm_err_i = wbm_cyc_o & wbm_stb_o & err_arm & (wbm_adr_o == err_adr);
  assign wbm_ack_i = wbm_cyc_o & wbm_stb_o & ~(err_drop & wbm_err_i);
  assign wbm_dat_i = wbm_adr_o ^ 32'hDEAD0000;

  wb_burst_reader #(.BURST_LEN(8), .FIFO_DEPTH(32), .CNT_W(16)) dut (
    .wb_clk(wb_clk), .wb_rst_n(wb_rst_n), .start_i(start_i), .base_adr_i(base_adr_i),
    .xfer_words_i(xfer_words_i), .busy_o(busy_o), .done_o(done_o), .err_o(err_o),
    .wbm_adr_o(wbm_adr_o), .wbm_bte_o(wbm_bte_o), .wbm_cti_o(wbm_cti_o), .wbm_cyc_o(wbm_cyc_o),
    .wbm_stb_o(wbm_stb_o), .wbm_we_o(wbm_we_o), .wbm_sel_o(wbm_sel_o), .wbm_dat_o(wbm_dat_o),
    .wbm_dat_i(wbm_dat_i), .wbm_ack_i(wbm_ack_i), .wbm_err_i(wbm_err_i), .wbm_rty_i(wbm_rty_i),
    .rd_data_o(rd_data_o), .rd_valid_o(rd_valid_o), .rd_ready_i(rd_ready_i),
    .fifo_level_o(fifo_level_o)
  );

  always @(negedge wb_clk) begin
    cyc_n++;
    if (wbm_ack_i) begin
      adr_q.push_back(wbm_adr_o);
      cti_q.push_back(wbm_cti_o);
      last_ack_cyc = cyc_n;
    end
    if (done_o) done_cyc = cyc_n;
    if (rd_valid_o && rd_ready_i) rx_q.push_back(rd_data_o);
    if (int'(fifo_level_o) > max_level) max_level = int'(fifo_level_o);
    if (wbm_cyc_o) begin
      if (!cyc_prev) gap_q.push_back(low_run);
      low_run = 0;
      cyc_cnt++;
    end else begin
      low_run++;
    end
    cyc_prev = wbm_cyc_o;
    if (busy_o) busy_cnt++;
  end

  task automatic clear_logs();
    adr_q.delete(); cti_q.delete(); rx_q.delete(); gap_q.delete();
    max_level = 0; cyc_cnt = 0; busy_cnt = 0;
  endtask

  task automatic pulse_start(input logic [31:0] base, input logic [15:0] words);
    @(posedge wb_clk); #1;
    start_i = 1'b1; base_adr_i = base; xfer_words_i = words;
    @(posedge wb_clk); #1;
    start_i = 1'b0;
  endtask

  task automatic wait_done(input string name, input int budget);
    logic got = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge wb_clk);
      if (done_o === 1'b1) begin got = 1'b1; break; end
    end
    #1;
    checks++;
    if (!got) begin
      errors++;
      $display("FAIL %s: done_o not seen within %0d cycles (got 0, want 1)", name, budget);
    end
  endtask

  task automatic check_rx(input string name, input logic [31:0] base, input int n);
    int bad = -1;
    for (int i = 0; i < n && i < rx_q.size(); i++)
      if (rx_q[i] !== ((base + 32'(4 * i)) ^ 32'hDEAD0000) && bad < 0) bad = i;
    checks++;
    if (rx_q.size() != n || bad >= 0) begin
      errors++;
      $display("FAIL %s: received %0d words first bad idx %0d, want %0d words in order", name, rx_q.size(), bad, n);
    end
  endtask

  task automatic test_reset();
    @(negedge wb_clk);
    checks++;
    if ({busy_o, done_o, err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, rd_valid_o} !== 7'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0000000",
        {busy_o, done_o, err_o, wbm_cyc_o, wbm_stb_o, wbm_we_o, rd_valid_o});
    end
    checks++;
    if (wbm_sel_o !== 4'hF || wbm_bte_o !== 2'b00 || wbm_cti_o !== 3'b000) begin
      errors++; $display("FAIL reset_sel: sel %h bte %b cti %b want F 00 000", wbm_sel_o, wbm_bte_o, wbm_cti_o);
    end
    checks++;
    if (wbm_adr_o !== 32'h0 || wbm_dat_o !== 32'h0 || rd_data_o !== 32'h0 || fifo_level_o !== 6'd0) begin
      errors++; $display("FAIL reset_data: adr %h dat %h rd %h lvl %0d want all 0",
        wbm_adr_o, wbm_dat_o, rd_data_o, fifo_level_o);
    end
  endtask

  task automatic test_single_burst();
    int bad = -1;
    clear_logs();
    rd_ready_i = 1'b1;
    pulse_start(32'h0000_0101, 16'd8);
    checks++;
    if (busy_o !== 1'b1) begin errors++; $display("FAIL t1_busy: got %b want 1", busy_o); end
    wait_done("t1_done", 100);
    checks++;
    if (busy_o !== 1'b0) begin errors++; $display("FAIL t1_busy_clr: got %b want 0", busy_o); end
    checks++;
    if (done_cyc - last_ack_cyc != 1) begin
      errors++; $display("FAIL t1_done_lat: got %0d want 1", done_cyc - last_ack_cyc);
    end
    for (int i = 0; i < 8 && i < adr_q.size(); i++)
      if (adr_q[i] !== 32'h100 + 32'(4 * i) || cti_q[i] !== ((i == 7) ? 3'b111 : 3'b010))
        if (bad < 0) bad = i;
    checks++;
    if (adr_q.size() != 8 || bad >= 0) begin
      errors++; $display("FAIL t1_beats: got %0d beats bad idx %0d, want 8 at 0x100.. cti 010x7,111", adr_q.size(), bad);
    end
    repeat (4) @(negedge wb_clk);
    check_rx("t1_data", 32'h100, 8);
  endtask

  task automatic test_multi_burst();
    int bad = -1;
    clear_logs();
    rd_ready_i = 1'b1;
    pulse_start(32'h0000_0200, 16'd19);
    repeat (4) @(negedge wb_clk);
    pulse_start(32'h0000_0900, 16'd5);
    wait_done("t2_done", 200);
    for (int i = 0; i < 19 && i < adr_q.size(); i++)
      if (adr_q[i] !== 32'h200 + 32'(4 * i) ||
          cti_q[i] !== ((i == 7 || i == 15 || i == 18) ? 3'b111 : 3'b010))
        if (bad < 0) bad = i;
    checks++;
    if (adr_q.size() != 19 || bad >= 0) begin
      errors++; $display("FAIL t2_beats: got %0d beats bad idx %0d, want 19 split 8/8/3", adr_q.size(), bad);
    end
    checks++;
    if (adr_q.size() == 0 || adr_q[adr_q.size() - 1] !== 32'h248) begin
      errors++; $display("FAIL t2_last_adr: got %h want 00000248", (adr_q.size() > 0) ? adr_q[adr_q.size() - 1] : 32'hX);
    end
    checks++;
    if (gap_q.size() != 3 || gap_q[1] != 1 || gap_q[2] != 1) begin
      errors++; $display("FAIL t2_gaps: got %0d bursts gaps %0d/%0d, want 3 bursts gaps 1/1",
        gap_q.size(), (gap_q.size() > 1) ? gap_q[1] : -1, (gap_q.size() > 2) ? gap_q[2] : -1);
    end
    repeat (4) @(negedge wb_clk);
    check_rx("t2_data", 32'h200, 19);
  endtask

  task automatic test_backpressure();
    logic hit = 1'b0;
    clear_logs();
    rd_ready_i = 1'b0;
    pulse_start(32'h0000_1000, 16'd64);
    for (int i = 0; i < 300; i++) begin
      @(negedge wb_clk);
      if (fifo_level_o == 6'd32) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL t3_fill: level %0d want 32", fifo_level_o); end
    repeat (20) @(negedge wb_clk);
    checks++;
    if (adr_q.size() != 32) begin errors++; $display("FAIL t3_stall: beats %0d want 32", adr_q.size()); end
    @(posedge wb_clk); #1 rd_ready_i = 1'b1;
    repeat (7) @(posedge wb_clk);
    #1 rd_ready_i = 1'b0;
    repeat (15) @(negedge wb_clk);
    checks++;
    if (adr_q.size() != 32 || fifo_level_o != 6'd25) begin
      errors++; $display("FAIL t3_seven_free: beats %0d lvl %0d want 32 25", adr_q.size(), fifo_level_o);
    end
    @(posedge wb_clk); #1 rd_ready_i = 1'b1;
    @(posedge wb_clk); #1 rd_ready_i = 1'b0;
    repeat (20) @(negedge wb_clk);
    checks++;
    if (adr_q.size() != 40 || fifo_level_o != 6'd32) begin
      errors++; $display("FAIL t3_eight_free: beats %0d lvl %0d want 40 32", adr_q.size(), fifo_level_o);
    end
    rd_ready_i = 1'b1;
    wait_done("t3_done", 500);
    repeat (40) @(negedge wb_clk);
    check_rx("t3_data", 32'h1000, 64);
    checks++;
    if (max_level != 32) begin errors++; $display("FAIL t3_max_level: got %0d want 32", max_level); end
  endtask

  task automatic test_zero_words();
    clear_logs();
    pulse_start(32'h0000_0700, 16'd0);
    @(negedge wb_clk);
    checks++;
    if (done_o !== 1'b1 || busy_o !== 1'b0) begin
      errors++; $display("FAIL t4_done: done %b busy %b want 1 0", done_o, busy_o);
    end
    repeat (5) @(negedge wb_clk);
    checks++;
    if (cyc_cnt != 0 || busy_cnt != 0) begin
      errors++; $display("FAIL t4_no_cycle: cyc %0d busy %0d want 0 0", cyc_cnt, busy_cnt);
    end
  endtask

  task automatic test_async_reset();
    logic hit = 1'b0;
    clear_logs();
    rd_ready_i = 1'b0;
    pulse_start(32'h0000_0300, 16'd8);
    for (int i = 0; i < 50; i++) begin
      @(negedge wb_clk);
      if (wbm_ack_i && wbm_adr_o == 32'h308) begin hit = 1'b1; break; end
    end
    checks++;
    if (!hit) begin errors++; $display("FAIL t5_third_beat: not reached (got 0 want 1)"); end
    #1 wb_rst_n = 1'b0;
    #1;
    checks++;
    if ({wbm_cyc_o, wbm_stb_o, rd_valid_o, busy_o} !== 4'b0 || fifo_level_o !== 6'd0) begin
      errors++; $display("FAIL t5_reset_drop: cyc/stb/valid/busy %b lvl %0d want 0000 0",
        {wbm_cyc_o, wbm_stb_o, rd_valid_o, busy_o}, fifo_level_o);
    end
    repeat (2) @(negedge wb_clk);
    wb_rst_n = 1'b1;
    clear_logs();
    rd_ready_i = 1'b1;
    pulse_start(32'h0000_0400, 16'd4);
    wait_done("t5_restart_done", 100);
    repeat (4) @(negedge wb_clk);
    check_rx("t5_restart_data", 32'h400, 4);
  endtask

  task automatic test_bus_error();
    clear_logs();
    err_adr = 32'h50C;
    err_arm = 1'b1;
`ifdef WB_READER_ERR_EN
    err_drop = 1'b1;
    rd_ready_i = 1'b0;
    pulse_start(32'h0000_0500, 16'd8);
    wait_done("t6_done", 100);
    checks++;
    if (err_o !== 1'b1 || fifo_level_o !== 6'd3 || adr_q.size() != 3) begin
      errors++; $display("FAIL t6_abort: err %b lvl %0d beats %0d want 1 3 3", err_o, fifo_level_o, adr_q.size());
    end
    rd_ready_i = 1'b1;
    repeat (6) @(negedge wb_clk);
    check_rx("t6_kept", 32'h500, 3);
    checks++;
    if (err_o !== 1'b1) begin errors++; $display("FAIL t6_sticky: got %b want 1", err_o); end
    err_arm = 1'b0;
    pulse_start(32'h0000_0600, 16'd2);
    @(negedge wb_clk);
    checks++;
    if (err_o !== 1'b0) begin errors++; $display("FAIL t6_clear: got %b want 0", err_o); end
    wait_done("t6_next_done", 100);
`else
    err_drop = 1'b0;
    rd_ready_i = 1'b1;
    pulse_start(32'h0000_0500, 16'd8);
    wait_done("t6_done", 100);
    checks++;
    if (err_o !== 1'b0 || adr_q.size() != 8) begin
      errors++; $display("FAIL t6_err_ignored: err %b beats %0d want 0 8", err_o, adr_q.size());
    end
    repeat (4) @(negedge wb_clk);
    check_rx("t6_data", 32'h500, 8);
`endif
    err_arm = 1'b0;
    err_drop = 1'b0;
  endtask

  initial begin
    #12 test_reset();
    @(posedge wb_clk); #1 wb_rst_n = 1'b1;
    test_single_burst();
    test_multi_burst();
    test_backpressure();
    test_zero_words();
    test_async_reset();
    test_bus_error();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
